ref_gray_conv_pipe: RTL and testbench

REF_GRAY_CONV_PIPE -- requirements
Module: ref_gray_conv_pipe

---
 rtl/ref_gray_conv_pipe_if.sv | 24 ++
 rtl/ref_gray_conv_pipe.sv | 147 ++++++++++++++
 tb/tb_ref_gray_conv_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ref_gray_conv_pipe_if.sv
// Handshake bundle for ref_gray_conv_pipe: the input beat channel and the output beat channel.
// The master drives beats in and accepts results; the slave is the converter.
interface ref_gray_conv_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_mode;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_mode, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_mode, out_data
   );
endinterface

// File: rtl/ref_gray_conv_pipe.sv
// Pipelined gray<->binary converter with valid/ready flow control on both sides.
// Optional sticky gray-sequence checker enabled by defining REF_GRAY_CONV_PIPE_CHECK_EN.
module ref_gray_conv_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ref_gray_conv_pipe_if.slave  bus,
   input  logic                 chk_clr,
   output logic                 chk_err
);

   // Gray-to-binary prefix is split into MSB-first chunks, one chunk per stage.
   localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] d);
      return d ^ (d >> 1);
   endfunction

   // Bits above this stage's chunk are already binary, so r[i+1] carries the running prefix.
   function automatic logic [WIDTH-1:0] g2b_chunk(input logic [WIDTH-1:0] d, input int s);
      logic [WIDTH-1:0] r;
      int               hi;
      int               lo;
      r  = d;
      hi = WIDTH - 1 - s * CHUNK;
      lo = WIDTH - (s + 1) * CHUNK;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         r[i] = (i <= hi && i >= lo) ? (d[i] ^ r[i+1]) : r[i];
      end
      return r;
   endfunction

   function automatic logic multi_bit(input logic [WIDTH-1:0] x);
      return |(x & (x - WIDTH'(1)));
   endfunction

   logic [STAGES-1:0] vld_r;
   logic [STAGES-1:0] mode_r;
   logic [WIDTH-1:0]  data_r     [STAGES];
   logic [STAGES:0]   take_s;
   logic [STAGES-1:0] up_vld_s;
   logic [STAGES-1:0] up_mode_s;
   logic [WIDTH-1:0]  up_data_s  [STAGES];
   logic [WIDTH-1:0]  nxt_data_s [STAGES];

   // Ready ripples back from the output: a stage may load when empty or when it drains.
   always_comb begin
      take_s         = '0;
      take_s[STAGES] = bus.out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         take_s[s] = ~vld_r[s] | take_s[s+1];
      end
   end

   // Per-stage source selection and the conversion slice applied on entry to each stage.
   always_comb begin
      up_vld_s     = '0;
      up_mode_s    = '0;
      up_vld_s[0]  = bus.in_valid;
      up_mode_s[0] = bus.in_mode;
      up_data_s[0] = bus.in_data;
      for (int s = 1; s < STAGES; s++) begin
         up_vld_s[s]  = vld_r[s-1];
         up_mode_s[s] = mode_r[s-1];
         up_data_s[s] = data_r[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
         if (up_mode_s[s]) begin
            nxt_data_s[s] = (s == 0) ? bin2gray(up_data_s[s]) : up_data_s[s];
         end else begin
            nxt_data_s[s] = g2b_chunk(up_data_s[s], s);
         end
      end
   end

   // Pipeline stage registers; reset discards every in-flight beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_r  <= '0;
         mode_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_r[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (take_s[s]) begin
               vld_r[s] <= up_vld_s[s];
               if (up_vld_s[s]) begin
                  data_r[s] <= nxt_data_s[s];
                  mode_r[s] <= up_mode_s[s];
               end
            end
         end
      end
   end

   assign bus.in_ready  = rst_n & take_s[0];
   assign bus.out_valid = vld_r[STAGES-1];
   assign bus.out_mode  = mode_r[STAGES-1];
   assign bus.out_data  = data_r[STAGES-1];

`ifdef REF_GRAY_CONV_PIPE_CHECK_EN
   logic [WIDTH-1:0] hist_r;
   logic             hist_vld_r;
   logic             chk_err_r;
   logic             acc0_s;
   logic             err_set_s;

   // An accepted mode-0 beat must differ from the previous one in at most one bit.
   always_comb begin
      acc0_s = bus.in_valid & bus.in_ready & ~bus.in_mode;
      if (acc0_s && hist_vld_r) begin
         err_set_s = multi_bit(bus.in_data ^ hist_r);
      end else begin
         err_set_s = 1'b0;
      end
   end

   // History of the last mode-0 beat and the sticky error; a new error beats a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_r     <= '0;
         hist_vld_r <= 1'b0;
         chk_err_r  <= 1'b0;
      end else begin
         if (acc0_s) begin
            hist_r     <= bus.in_data;
            hist_vld_r <= 1'b1;
         end
         if (err_set_s) begin
            chk_err_r <= 1'b1;
         end else if (chk_clr) begin
            chk_err_r <= 1'b0;
         end
      end
   end

   assign chk_err = chk_err_r;
`else
   logic unused_chk_clr_s;
   assign unused_chk_clr_s = chk_clr;
   assign chk_err          = 1'b0;
`endif

endmodule

// File: tb/tb_ref_gray_conv_pipe.sv
// Directed bench for ref_gray_conv_pipe: latency vectors at several widths, sweeps,
// a randomly stalled stream against a scoreboard, mid-flight reset and the sequence checker.
module tb_ref_gray_conv_pipe;

`ifdef REF_GRAY_CONV_PIPE_CHECK_EN
   localparam logic CHK_ON = 1'b1;
`else
   localparam logic CHK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic chk_clr;
   logic chk_err8, chk_err64, chk_err1;
   int   nvec = 0;
   int   nmis = 0;

   always #5 clk = ~clk;

   ref_gray_conv_pipe_if #(.WIDTH(8))  b8 ();
   ref_gray_conv_pipe_if #(.WIDTH(64)) b64 ();
   ref_gray_conv_pipe_if #(.WIDTH(1))  b1 ();

   ref_gray_conv_pipe #(.WIDTH(8), .STAGES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .bus(b8), .chk_clr(chk_clr), .chk_err(chk_err8));
   ref_gray_conv_pipe #(.WIDTH(64), .STAGES(4)) u64 (
      .clk(clk), .rst_n(rst_n), .bus(b64), .chk_clr(1'b0), .chk_err(chk_err64));
   ref_gray_conv_pipe #(.WIDTH(1), .STAGES(3)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b1), .chk_clr(1'b0), .chk_err(chk_err1));

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_g2b8(input logic [7:0] g);
      logic [7:0] b;
      b = g;
      b = b ^ (b >> 1);
      b = b ^ (b >> 2);
      b = b ^ (b >> 4);
      return b;
   endfunction

   function automatic logic [7:0] ref_b2g8(input logic [7:0] b);
      return b ^ {1'b0, b[7:1]};
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b8.in_valid  = 1'b0; b8.in_mode  = 1'b0; b8.in_data  = 8'h00; b8.out_ready  = 1'b1;
      b64.in_valid = 1'b0; b64.in_mode = 1'b0; b64.in_data = 64'h0; b64.out_ready = 1'b1;
      b1.in_valid  = 1'b0; b1.in_mode  = 1'b0; b1.in_data  = 1'b0;  b1.out_ready  = 1'b1;
   endtask

   task automatic drive_beat(input int sel, input logic v, input logic m, input logic [63:0] d);
      case (sel)
         0:       begin b8.in_valid = v;  b8.in_mode = m;  b8.in_data = d[7:0]; end
         1:       begin b64.in_valid = v; b64.in_mode = m; b64.in_data = d; end
         default: begin b1.in_valid = v;  b1.in_mode = m;  b1.in_data = d[0]; end
      endcase
   endtask

   task automatic peek(input int sel, output logic rdy, output logic ov, output logic [63:0] od);
      case (sel)
         0:       begin rdy = b8.in_ready;  ov = b8.out_valid;  od = {56'h0, b8.out_data}; end
         1:       begin rdy = b64.in_ready; ov = b64.out_valid; od = b64.out_data; end
         default: begin rdy = b1.in_ready;  ov = b1.out_valid;  od = {63'h0, b1.out_data}; end
      endcase
   endtask

   // One beat into an idle pipe; out_valid must rise exactly st cycles after acceptance.
   task automatic lat_beat(input int sel, input int st, input string tag, input logic m,
                           input logic [63:0] d, input logic [63:0] exp);
      logic        rdy, ov;
      logic [63:0] od;
      drive_beat(sel, 1'b1, m, d);
      peek(sel, rdy, ov, od);
      chk_eq({tag, "_rdy"}, 64'(rdy), 64'd1);
      nxt();
      drive_beat(sel, 1'b0, 1'b0, 64'h0);
      for (int k = 1; k <= st; k++) begin
         peek(sel, rdy, ov, od);
         if (k < st) begin
            chk_eq({tag, "_early"}, 64'(ov), 64'd0);
            nxt();
         end else begin
            chk_eq({tag, "_vld"}, 64'(ov), 64'd1);
            chk_eq({tag, "_data"}, od, exp);
         end
      end
      nxt();
   endtask

   task automatic send8(input logic m, input logic [7:0] d);
      b8.in_valid = 1'b1;
      b8.in_mode  = m;
      b8.in_data  = d;
      nxt();
      b8.in_valid = 1'b0;
   endtask

   // Stream n beats through the 8-bit pipe with random gaps and stalls, scoreboard checked.
   task automatic run_stream(input string tag, input int n, input int vprob, input int rprob,
                             input int msel, input logic sweep, input logic tput);
      logic [8:0] q[$];
      logic [8:0] e;
      logic [7:0] d, sd;
      logic       m, sm, stall;
      int         sent, got, cyc;
      sent = 0; got = 0; cyc = 0; stall = 1'b0; sd = 8'h00; sm = 1'b0; m = 1'b0; d = 8'h00;
      while (got < n && cyc < 20000) begin
         if (sent < n && $urandom_range(99) < vprob) begin
            d = sweep ? sent[7:0] : 8'($urandom);
            case (msel)
               0:       m = 1'b0;
               1:       m = 1'b1;
               2:       m = sent[0];
               default: m = 1'($urandom_range(1));
            endcase
            b8.in_valid = 1'b1; b8.in_mode = m; b8.in_data = d;
         end else begin
            b8.in_valid = 1'b0;
         end
         b8.out_ready = ($urandom_range(99) < rprob);
         @(negedge clk);
         if (stall) begin
            chk_eq({tag, "_hold_v"}, 64'(b8.out_valid), 64'd1);
            chk_eq({tag, "_hold_d"}, 64'(b8.out_data), 64'(sd));
            chk_eq({tag, "_hold_m"}, 64'(b8.out_mode), 64'(sm));
         end
         if (b8.in_valid && b8.in_ready) begin
            q.push_back({m, m ? ref_b2g8(d) : ref_g2b8(d)});
            sent++;
         end
         if (b8.out_valid && b8.out_ready) begin
            chk_eq({tag, "_known"}, 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk_eq({tag, "_data"}, 64'(b8.out_data), 64'(e[7:0]));
               chk_eq({tag, "_mode"}, 64'(b8.out_mode), 64'(e[8]));
            end
            got++;
         end
         chk_eq({tag, "_inflight"}, 64'(q.size() > 2), 64'd0);
         stall = b8.out_valid && !b8.out_ready;
         sd    = b8.out_data;
         sm    = b8.out_mode;
         @(posedge clk);
         #1;
         cyc++;
      end
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
      chk_eq({tag, "_count"}, 64'(got), 64'(n));
      if (tput) begin
         chk_eq({tag, "_cycles"}, 64'(cyc), 64'(n + 2));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      chk_clr = 1'b0;
      idle();
      nxt();
      nxt();
      chk_eq("rst_rdy", 64'(b8.in_ready), 64'd0);
      chk_eq("rst_ov", 64'(b8.out_valid), 64'd0);
      chk_eq("rst_od", 64'(b8.out_data), 64'd0);
      chk_eq("rst_om", 64'(b8.out_mode), 64'd0);
      chk_eq("rst_err", 64'(chk_err8), 64'd0);
      chk_eq("rst_ov64", 64'(b64.out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk_eq("rel_rdy", 64'(b8.in_ready), 64'd1);
      nxt();

      lat_beat(0, 2, "g2b_c6", 1'b0, 64'hC6, 64'h84);
      lat_beat(0, 2, "b2g_0f", 1'b1, 64'h0F, 64'h08);
      lat_beat(1, 4, "g2b_msb64", 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      lat_beat(1, 4, "g2b_c064", 1'b0, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000);
      lat_beat(1, 4, "g2b_lsb64", 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001);
      lat_beat(1, 4, "b2g_ff64", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
      lat_beat(2, 3, "w1_g1", 1'b0, 64'h1, 64'h1);
      lat_beat(2, 3, "w1_b1", 1'b1, 64'h1, 64'h1);
      lat_beat(2, 3, "w1_g0", 1'b0, 64'h0, 64'h0);

      run_stream("sweep_g2b", 256, 100, 100, 0, 1'b1, 1'b1);
      run_stream("sweep_b2g", 256, 100, 100, 1, 1'b1, 1'b1);
      run_stream("alt_mode", 64, 100, 100, 2, 1'b1, 1'b1);
      run_stream("random", 1000, 70, 60, 3, 1'b0, 1'b0);

      // Three beats parked in the 4-stage pipe, then a one-cycle reset.
      b64.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b64.in_valid = 1'b1; b64.in_mode = 1'b0; b64.in_data = 64'(i + 1);
         chk_eq("flight_rdy", 64'(b64.in_ready), 64'd1);
         nxt();
      end
      b64.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_rdy", 64'(b64.in_ready), 64'd0);
      nxt();
      chk_eq("mid_rst_ov", 64'(b64.out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk_eq("post_rst_rdy", 64'(b64.in_ready), 64'd1);
      chk_eq("post_rst_ov", 64'(b64.out_valid), 64'd0);
      b64.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         nxt();
         chk_eq("flushed_ov", 64'(b64.out_valid), 64'd0);
      end

      send8(1'b0, 8'h00);
      chk_eq("chk_first", 64'(chk_err8), 64'd0);
      send8(1'b0, 8'h03);
      chk_eq("chk_2bit", 64'(chk_err8), 64'(CHK_ON));
      chk_clr = 1'b1;
      nxt();
      chk_clr = 1'b0;
      chk_eq("chk_clr", 64'(chk_err8), 64'd0);
      send8(1'b0, 8'h01);
      chk_eq("chk_1bit_a", 64'(chk_err8), 64'd0);
      send8(1'b0, 8'h03);
      chk_eq("chk_1bit_b", 64'(chk_err8), 64'd0);
      chk_clr = 1'b1;
      send8(1'b0, 8'hFF);
      chk_clr = 1'b0;
      chk_eq("chk_clr_vs_set", 64'(chk_err8), 64'(CHK_ON));
      nxt();
      chk_eq("chk_sticky", 64'(chk_err8), 64'(CHK_ON));
      chk_clr = 1'b1;
      nxt();
      chk_clr = 1'b0;
      chk_eq("chk_clr2", 64'(chk_err8), 64'd0);
      send8(1'b1, 8'h00);
      send8(1'b0, 8'hFE);
      chk_eq("chk_mode1_skip", 64'(chk_err8), 64'd0);
      chk_eq("chk_off64", 64'(chk_err64), 64'd0);
      chk_eq("chk_off1", 64'(chk_err1), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
